// File: rtl/nand_bus_sequencer_if.sv
// nand_bus_if: request/response channel between the register front-end and the NAND sequencer
interface nand_bus_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic       req_keep_ce;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       cfg_wp;
  logic       busy;
  modport master (
    output req_valid, req_op, req_data, req_keep_ce, cfg_wp,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_op, req_data, req_keep_ce, cfg_wp,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/nand_bus_sequencer.sv
// nand_bus_sequencer: sequences single ONFI-style asynchronous NAND bus cycles with programmable timing
module nand_bus_sequencer #(
  parameter int          T_SETUP = 1,
  parameter int          T_WP    = 2,
  parameter int          T_WH    = 2,
  parameter int          T_WB    = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  nand_bus_if.slave  bus,
  output logic       nCE,
  output logic       CLE,
  output logic       ALE,
  output logic       nWE,
  output logic       nRE,
  output logic       nWP,
  output logic [7:0] IO_out,
  output logic       IO_oe,
  input  logic [7:0] IO_in,
  input  logic       RB_n
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] WB_DLY  = 3'd4;
  localparam logic [2:0] WAIT_RB = 3'd5;
  localparam logic [2:0] RESP    = 3'd6;
  localparam logic [15:0] TS_RAW = 16'(T_SETUP);
  localparam logic [15:0] TP_RAW = 16'(T_WP);
  localparam logic [15:0] TH_RAW = 16'(T_WH);
  localparam logic [15:0] TB_RAW = 16'(T_WB);
  localparam logic [15:0] TS = TS_RAW == 16'd0 ? 16'd1 : TS_RAW;
  localparam logic [15:0] TP = TP_RAW == 16'd0 ? 16'd1 : TP_RAW;
  localparam logic [15:0] TH = TH_RAW == 16'd0 ? 16'd1 : TH_RAW;
  localparam logic [15:0] TB = TB_RAW == 16'd0 ? 16'd1 : TB_RAW;
  logic [2:0]  state, nxt, op;
  logic [15:0] cnt, dur;
  logic        keep_ce, err, rb_q, rb_s, acc, legal, last;
  // next-state decode; dur is the length of the current timed phase
  always_comb begin
    acc   = bus.req_valid && bus.req_ready;
    legal = bus.req_op <= 3'd4;
    dur   = state == SETUP ? TS : state == STROBE ? TP : state == HOLD ? TH : TB;
    last  = cnt == dur - 16'd1;
    nxt   = state;
    case (state)
      IDLE, RESP: nxt = !acc ? IDLE : (legal && bus.req_op != 3'd4) ? SETUP : WB_DLY;
      SETUP:      nxt = last ? STROBE : SETUP;
      STROBE:     nxt = last ? HOLD : STROBE;
      HOLD:       nxt = last ? RESP : HOLD;
      WB_DLY:     nxt = err ? RESP : last ? WAIT_RB : WB_DLY;
      WAIT_RB:    nxt = (rb_s || cnt == TIMEOUT) ? RESP : WAIT_RB;
      default:    nxt = IDLE;
    endcase
  end
  // registered state, RB_n synchronizer and every pin/response output
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) begin
      state         <= IDLE;
      cnt           <= '0;
      op            <= '0;
      keep_ce       <= 1'b0;
      err           <= 1'b0;
      rb_q          <= 1'b1;
      rb_s          <= 1'b1;
      nCE           <= 1'b1;
      CLE           <= 1'b0;
      ALE           <= 1'b0;
      nWE           <= 1'b1;
      nRE           <= 1'b1;
      nWP           <= 1'b0;
      IO_out        <= '0;
      IO_oe         <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= nxt;
      cnt           <= nxt != state ? '0 : cnt + {15'd0, cnt != 16'hFFFF};
      rb_q          <= RB_n;
      rb_s          <= rb_q;
      nWP           <= !bus.cfg_wp;
      bus.req_ready <= nxt == IDLE || nxt == RESP;
      bus.busy      <= nxt != IDLE;
      bus.rsp_valid <= nxt == RESP;
      if (acc) begin
        op           <= bus.req_op;
        keep_ce      <= bus.req_keep_ce;
        err          <= !legal;
        bus.rsp_data <= '0;
      end
      if (nxt == SETUP && state != SETUP) begin
        nCE    <= 1'b0;
        CLE    <= bus.req_op == 3'd0;
        ALE    <= bus.req_op == 3'd1;
        IO_oe  <= bus.req_op != 3'd3;
        IO_out <= bus.req_data;
      end
      if (state == SETUP && last) begin
        nWE <= op == 3'd3;
        nRE <= op != 3'd3;
      end
      if (state == STROBE && last) begin
        nWE <= 1'b1;
        nRE <= 1'b1;
        if (op == 3'd3) bus.rsp_data <= IO_in;
      end
      if (nxt == RESP) begin
        CLE         <= 1'b0;
        ALE         <= 1'b0;
        IO_oe       <= 1'b0;
        bus.rsp_err <= state == WB_DLY ? err : (state == WAIT_RB && !rb_s);
        if (!err) nCE <= !keep_ce;
      end
    end
endmodule
